// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared encodings and defaults for the IFU fetch controller.
package ifu_fetch_ctrl_pkg;

  localparam int          FC_XLEN         = 32;
  localparam logic [31:0] FC_BOOT_IT_ADDR = 32'h0000_0000;
  localparam int          FC_IW           = 32;

  typedef enum logic [1:0] {
    FC_BOOT  = 2'd0,
    FC_IDLE  = 2'd1,
    FC_WAIT  = 2'd2,
    FC_DRAIN = 2'd3
  } fc_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl_fetch_buf.sv
// Small FIFO of {pc,instr} pairs between fetch and decode.
// Clear wins over push and pop in the same cycle.
module ifu_fetch_ctrl_fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    pop_ok;

  // A pop on an empty buffer is meaningless; drop it rather than corrupt count.
  assign pop_ok = pop & ~empty;

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch sequencer: owns the fetch PC, runs the imem req/ack handshake,
// follows BPU next-PC predictions and buffers fetched pairs toward decode.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int              XLEN      = FC_XLEN,
  parameter logic [XLEN-1:0] BOOT_ADDR = XLEN'(FC_BOOT_IT_ADDR),
  parameter int              FB_DEPTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [FC_IW-1:0] imem_rdata,
  output logic [XLEN-1:0]  bpu_pc,
  output logic [FC_IW-1:0] bpu_instr,
  input  logic [XLEN-1:0]  pred_pc,
  input  logic             flush_flag,
  input  logic [XLEN-1:0]  flush_addr,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc,
  output logic [FC_IW-1:0] if_instr,
  input  logic             if_ready
);

  localparam int CW = $clog2(FB_DEPTH) + 1;
  localparam int EW = XLEN + FC_IW;

  fc_state_e       state;
  logic [XLEN-1:0] fetch_pc;

  logic            fb_push;
  logic            fb_pop;
  logic            fb_full;
  logic            fb_empty;
  logic [CW-1:0]   fb_count;
  logic [EW-1:0]   fb_head;
  logic [CW:0]     cnt_after_ack;
  logic            room_idle;
  logic            room_ack;

  // The BPU sees the returning instruction alongside its address.
  assign bpu_pc    = imem_addr;
  assign bpu_instr = imem_rdata;

  assign fb_pop  = ~fb_empty & if_ready;
  assign fb_push = (state == FC_WAIT) & imem_ack & ~flush_flag;

  // Issue from IDLE only if a slot is free once this cycle's pop retires,
  // so count plus the outstanding request never exceeds FB_DEPTH.
  assign room_idle = ~fb_full | fb_pop;

  // Keep requesting back-to-back only if a slot stays free after push/pop.
  assign cnt_after_ack = {1'b0, fb_count} + (CW+1)'(1) - (CW+1)'(fb_pop);
  assign room_ack      = cnt_after_ack < (CW+1)'(FB_DEPTH);

  ifu_fetch_ctrl_fetch_buf #(
    .DEPTH (FB_DEPTH),
    .W     (EW),
    .CW    (CW)
  ) u_fetch_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (fb_push),
    .pop   (fb_pop),
    .clear (flush_flag),
    .wdata ({fetch_pc, imem_rdata}),
    .rdata (fb_head),
    .full  (fb_full),
    .empty (fb_empty),
    .count (fb_count)
  );

  // Head of buffer is registered state; present zeros when nothing is valid.
  assign if_valid = ~fb_empty;
  assign if_pc    = if_valid ? fb_head[EW-1:FC_IW] : '0;
  assign if_instr = if_valid ? fb_head[FC_IW-1:0]  : '0;

  // Controller FSM with registered request, address and fetch PC.
  // In WAIT, imem_addr always equals fetch_pc; in DRAIN it holds the
  // abandoned address because a request is never withdrawn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FC_BOOT;
      fetch_pc  <= BOOT_ADDR;
      imem_addr <= BOOT_ADDR;
      imem_req  <= 1'b0;
    end else begin
      if (flush_flag) fetch_pc <= flush_addr;
      case (state)
        FC_BOOT: state <= FC_IDLE;
        FC_IDLE: begin
          if (!flush_flag && room_idle) begin
            state     <= FC_WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        FC_WAIT: begin
          if (flush_flag) begin
            if (imem_ack) begin
              state    <= FC_IDLE;
              imem_req <= 1'b0;
            end else begin
              state    <= FC_DRAIN;
            end
          end else if (imem_ack) begin
            fetch_pc <= pred_pc;
            if (room_ack) begin
              imem_addr <= pred_pc;
            end else begin
              state    <= FC_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        FC_DRAIN: begin
          if (imem_ack) begin
            state    <= FC_IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= FC_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
